ram_io_responder: RTL and testbench
===================================

# ram_io_responder

Memory-side responder for the CPU's byte-wide memory bus. It owns the 128 KB RAM array and the memory-mapped I/O window (`mem_a[17:16]==2'b11`). It returns read bytes one cycle after the address, and accepts writes in the same cycle. It buffers UART output in a TX FIFO, exposes `io_buffer_full` back to the CPU, supplies UART input bytes and a free-running cycle counter, and sequences the program-stop handshake. It sits between `cpu` and the UART/host at SoC top level.

## Interface
- `RAM_AW`, 17: RAM byte-address width. Array size is 2^RAM_AW bytes.
- `TXQ_DEPTH`, 8: TX FIFO depth in bytes. Must be a power of 2 and ≥ 4.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous, active-high reset.
- `mem_a` in 32: CPU address. Only bits [17:0] are decoded.
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_dout` in 8: write data from the CPU.
- `mem_din` out 8: read data to the CPU, registered.
- `io_buffer_full` out 1: TX FIFO near-full indication to the CPU.
- `rx_valid` in 1, `rx_data` in 8: incoming UART byte, offered to the block.
- `rx_ready` out 1: RX holding register is empty.
- `tx_valid` out 1, `tx_data` out 8: outgoing UART byte.
- `tx_ready` in 1: UART accepts the byte on `tx_valid & tx_ready`.
- `tx_overflow` out 1: sticky; a write arrived while the TX FIFO was full.
- `program_stop` out 1: high once the stop sequence has completed.

## Operation
- Decode: `io = mem_a[17:16]==2'b11`. RAM index is `mem_a[RAM_AW-1:0]`.
- RAM read: `mem_din` takes `ram[idx]` at the next edge.
- RAM write: `ram[idx] <= mem_dout`.
- I/O read 0x30000: returns the RX holding byte and clears it. Returns 0x00 if it is empty.
- I/O read 0x30004–0x30007: returns byte `mem_a[1:0]` of `cnt_snap`, little-endian.
  - A read of 0x30004 loads `cnt_snap <= cycle_cnt` at that same edge.
  - The 0x30004 read therefore returns byte 0 of the pre-snapshot counter value.
- Other I/O addresses: read 0x00, writes ignored.
- I/O write 0x30000:
  - Nonzero data is pushed to the TX FIFO.
  - 0x00 is ignored.
  - A write while the FIFO is full is dropped and sets `tx_overflow`.
- I/O write 0x30004: starts the stop sequence.
- `cycle_cnt`: 32-bit counter, +1 every cycle out of reset, wraps 0xFFFFFFFF→0.
- RX holding register:
  - Loaded on `rx_valid & rx_ready`.
  - If a 0x30000 read and an RX load occur in the same cycle, the read returns the old byte and the holding register takes the new one.
- TX FIFO:
  - Head drives `tx_data`. `tx_valid = !empty`.
  - Pop on `tx_valid & tx_ready`.
  - Simultaneous push and pop: count unchanged. A push is legal when full if a pop happens in the same cycle.
  - Pointers wrap modulo `TXQ_DEPTH`.
- `io_buffer_full = (count >= TXQ_DEPTH-2)`. This leaves slack for one in-flight CPU write plus one register stage.
- Stop FSM states: RUN, DRAIN, TERM, HALT.
  - RUN → DRAIN on a write to 0x30004.
  - DRAIN: further 0x30000 writes are dropped without setting overflow. Exit to TERM when the FIFO is empty and no pop occurs.
  - TERM: drives `tx_valid=1`, `tx_data=0x00`. Moves to HALT on `tx_ready`.
  - HALT: `program_stop=1`. RAM accesses are still served. `tx_valid=0`.

## Timing
- Read latency is exactly 1 cycle: address at edge N, data valid after edge N+1. `mem_din` holds its value until the next read.
- A write takes effect at the edge it is presented. A read of the same address in the next cycle returns the new data.
- `io_buffer_full` is combinational from the FIFO count. It updates the cycle after a push or pop.
- Reset values:
  - `mem_din`=0, `io_buffer_full`=0, `rx_ready`=1, `tx_valid`=0, `tx_data`=0.
  - `tx_overflow`=0, `program_stop`=0.
  - `cycle_cnt`=0, `cnt_snap`=0, FIFO empty, FSM=RUN.
- RAM contents are not reset.
- Reset mid-DRAIN or mid-TERM discards queued bytes. No terminating 0x00 is sent.

## Test plan
- Write 0xA5 to 0x00100, then read 0x00100 in the next cycle → `mem_din`=0xA5 one cycle after the read address.
- With `tx_ready`=0, write 'H','i',0x00,'!' to 0x30000 → FIFO count=3. `io_buffer_full`=0 when `TXQ_DEPTH`=8. Raise `tx_ready` → `tx_data` sequence 0x48, 0x69, 0x21.
- With `tx_ready`=0, push 7 bytes → `io_buffer_full`=1 after the 6th push. Push 2 more → the 9th is dropped and `tx_overflow`=1.
- Release reset, wait until `cycle_cnt`=0x00000123 is loaded at the edge of a 0x30004 read, then read 0x30005–0x30007 → bytes 0x23, 0x01, 0x00, 0x00.
- Offer `rx_data`=0x37 → `rx_ready`=0. Read 0x30000 → returns 0x37 and `rx_ready`=1. A second read returns 0x00.
- Queue 2 bytes, write 0x30004 → both bytes sent, then 0x00. `program_stop`=1 the cycle after the 0x00 handshake. A write to 0x30000 during DRAIN emits nothing.

Source files
------------

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - CPU memory-side responder: 128 KB RAM, UART I/O window, TX FIFO, stop sequencer
module ram_io_responder #(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_overflow,
  output logic        program_stop
);

  localparam int PW = $clog2(TXQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TXQ_DEPTH);
  localparam logic [CW-1:0] NEAR_C  = CW'(TXQ_DEPTH - 2);

  typedef enum logic [1:0] {RUN, DRAIN, TERM, HALT} state_t;

  state_t          state;
  logic [7:0]      ram [0:(1<<RAM_AW)-1];
  logic [7:0]      txq [0:TXQ_DEPTH-1];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     cycle_cnt, cnt_snap;
  logic [7:0]      rx_byte;
  logic            rx_full;

  logic [RAM_AW-1:0] idx;
  logic io, io_rx, io_cnt;
  logic rd_rx, wr_tx, wr_stop, rd_snap;
  logic fifo_valid, fifo_full, pop, push_req, push;
  logic unused_addr_bits;

  assign idx     = mem_a[RAM_AW-1:0];
  assign io      = (mem_a[17:16] == 2'b11);
  assign io_rx   = io && (mem_a[15:0] == 16'h0000);
  assign io_cnt  = io && (mem_a[15:2] == 14'h0001);
  assign rd_rx   = io_rx && !mem_wr;
  assign wr_tx   = io_rx && mem_wr;
  assign wr_stop = io_cnt && mem_wr && (mem_a[1:0] == 2'b00);
  assign rd_snap = io_cnt && !mem_wr && (mem_a[1:0] == 2'b00);
  assign unused_addr_bits = ^mem_a[31:18];

  // FIFO is always empty in TERM/HALT, so the head mux alone yields the 0x00 terminator
  assign fifo_valid     = (count != '0);
  assign fifo_full      = (count == DEPTH_C);
  assign tx_valid       = fifo_valid || (state == TERM);
  assign tx_data        = fifo_valid ? txq[rd_ptr] : 8'h00;
  assign pop            = fifo_valid && tx_ready;
  assign push_req       = wr_tx && (mem_dout != 8'h00) && (state == RUN);
  assign push           = push_req && (!fifo_full || pop);
  assign io_buffer_full = (count >= NEAR_C);
  assign rx_ready       = !rx_full;
  assign program_stop   = (state == HALT);

  always_ff @(posedge clk_in) begin
    if (mem_wr && !io) ram[idx] <= mem_dout;
    if (push) txq[wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= RUN;
      mem_din     <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cycle_cnt   <= 32'h0;
      cnt_snap    <= 32'h0;
      rx_byte     <= 8'h00;
      rx_full     <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;

      if (!mem_wr) begin
        if (!io)         mem_din <= ram[idx];
        else if (io_rx)  mem_din <= rx_full ? rx_byte : 8'h00;
        else if (rd_snap) mem_din <= cycle_cnt[7:0];
        else if (io_cnt) mem_din <= cnt_snap[{mem_a[1:0], 3'b000} +: 8];
        else             mem_din <= 8'h00;
      end
      if (rd_snap) cnt_snap <= cycle_cnt;

      // A load in the same cycle as a read wins, so the new byte is not lost
      if (rd_rx) rx_full <= 1'b0;
      if (rx_valid && !rx_full) begin
        rx_full <= 1'b1;
        rx_byte <= rx_data;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop) tx_overflow <= 1'b1;

      case (state)
        RUN:     if (wr_stop) state <= DRAIN;
        DRAIN:   if (!fifo_valid && !pop) state <= TERM;
        TERM:    if (tx_ready) state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - directed self-checking bench for ram_io_responder
module tb_ram_io_responder;

  localparam logic [31:0] PARK = 32'h0001_FF00;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_overflow;
  logic        program_stop;

  int vectors = 0;
  int miscompares = 0;

  ram_io_responder #(.RAM_AW(17), .TXQ_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_overflow(tx_overflow), .program_stop(program_stop)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] data);
    mem_a = addr; mem_wr = 1'b1; mem_dout = data;
    tick();
    mem_wr = 1'b0; mem_a = PARK;
  endtask

  task automatic rd(input logic [31:0] addr);
    mem_a = addr; mem_wr = 1'b0;
    tick();
    mem_a = PARK;
  endtask

  initial begin
    rst_in = 1'b1; mem_a = PARK; mem_wr = 1'b0; mem_dout = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    tick(); tick();
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_io_full", io_buffer_full, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_overflow", tx_overflow, 1'b0);
    chk("rst_stop", program_stop, 1'b0);

    // counter reaches 0x123 after 0x123 non-reset edges
    rst_in = 1'b0;
    repeat (32'h123) tick();
    rd(32'h30004); chk("snap_b0", mem_din, 8'h23);
    rd(32'h30005); chk("snap_b1", mem_din, 8'h01);
    rd(32'h30006); chk("snap_b2", mem_din, 8'h00);
    rd(32'h30007); chk("snap_b3", mem_din, 8'h00);

    wr(32'h00100, 8'hA5);
    rd(32'h00100); chk("ram_rd_100", mem_din, 8'hA5);
    wr(32'h10100, 8'h3C);
    rd(32'h10100); chk("ram_rd_10100", mem_din, 8'h3C);
    rd(32'h00100); chk("ram_rd_100_again", mem_din, 8'hA5);
    rd(32'h30010); chk("io_other_rd", mem_din, 8'h00);

    rx_valid = 1'b1; rx_data = 8'h37;
    tick();
    rx_valid = 1'b0;
    chk("rx_ready_loaded", rx_ready, 1'b0);
    rd(32'h30000); chk("rx_rd_37", mem_din, 8'h37);
    chk("rx_ready_cleared", rx_ready, 1'b1);
    rd(32'h30000); chk("rx_rd_empty", mem_din, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h55;
    rd(32'h30000);
    rx_valid = 1'b0;
    chk("rx_same_cycle_old", mem_din, 8'h00);
    chk("rx_same_cycle_ready", rx_ready, 1'b0);
    rd(32'h30000); chk("rx_same_cycle_new", mem_din, 8'h55);

    wr(32'h30000, 8'h48); wr(32'h30000, 8'h69);
    wr(32'h30000, 8'h00); wr(32'h30000, 8'h21);
    chk("hi_io_full", io_buffer_full, 1'b0);
    chk("hi_valid", tx_valid, 1'b1);
    tx_ready = 1'b1;
    chk("hi_tx0", tx_data, 8'h48); tick();
    chk("hi_tx1", tx_data, 8'h69); tick();
    chk("hi_tx2", tx_data, 8'h21); tick();
    chk("hi_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    for (int i = 1; i <= 5; i++) wr(32'h30000, 8'(i));
    chk("near_full_5", io_buffer_full, 1'b0);
    wr(32'h30000, 8'h06);
    chk("near_full_6", io_buffer_full, 1'b1);
    wr(32'h30000, 8'h07); wr(32'h30000, 8'h08);
    chk("ovf_at_8", tx_overflow, 1'b0);
    wr(32'h30000, 8'h09);
    chk("ovf_at_9", tx_overflow, 1'b1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", tx_data, 32'(i));
      tick();
    end
    chk("drain_empty", tx_valid, 1'b0);
    chk("drain_io_full", io_buffer_full, 1'b0);
    tx_ready = 1'b0;

    rst_in = 1'b1; tick(); rst_in = 1'b0;
    chk("rst2_overflow", tx_overflow, 1'b0);
    wr(32'h30000, 8'h11); wr(32'h30000, 8'h22);
    wr(32'h30004, 8'h00);
    wr(32'h30000, 8'h33);
    chk("drain_no_ovf", tx_overflow, 1'b0);
    chk("drain_no_stop", program_stop, 1'b0);
    tx_ready = 1'b1;
    chk("stop_tx0", tx_data, 8'h11); tick();
    chk("stop_tx1", tx_data, 8'h22); tick();
    chk("stop_drop_33", tx_valid, 1'b0); tick();
    chk("term_valid", tx_valid, 1'b1);
    chk("term_data", tx_data, 8'h00);
    chk("term_no_stop", program_stop, 1'b0);
    tick();
    chk("halt_stop", program_stop, 1'b1);
    chk("halt_valid", tx_valid, 1'b0);
    wr(32'h00200, 8'h5A);
    rd(32'h00200); chk("halt_ram", mem_din, 8'h5A);
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    chk("rst3_stop", program_stop, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
